// File: rtl/tdm_mux8_tx_pkg.sv
// Shared constants and state encoding for the 8-channel TDM transmit path.
package tdm_mux8_tx_pkg;

    localparam int CH_NUM = 8;
    localparam int SEL_W  = 3;

    localparam logic [SEL_W-1:0] FIRST_SEL = '0;
    localparam logic [SEL_W-1:0] LAST_SEL  = SEL_W'(CH_NUM - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/tdm_mux8_tx_slice.sv
// Combinational 8:1 channel selector, WIDTH bits per channel.
module mux8_slice
    import tdm_mux8_tx_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [CH_NUM*WIDTH-1:0] i_data,
    input  logic [SEL_W-1:0]        i_sel,
    output logic [WIDTH-1:0]        o_data
);

    logic [WIDTH-1:0] w_ch [CH_NUM];

    // Unpack the flat bus so the select is a plain array index.
    for (genvar g = 0; g < CH_NUM; g++) begin : g_unpack
        assign w_ch[g] = i_data[g*WIDTH +: WIDTH];
    end

    assign o_data = w_ch[i_sel];

endmodule

// File: rtl/tdm_mux8_tx.sv
// 8-to-1 TDM transmitter: snapshots eight channels on start, then sends one
// channel per accepted beat with a channel index the receive demux can decode.
module tdm_mux8_tx
    import tdm_mux8_tx_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [CH_NUM*WIDTH-1:0] din,
    input  logic                    ready,
    output logic [WIDTH-1:0]        out,
    output logic [SEL_W-1:0]        sel,
    output logic                    valid,
    output logic                    sof,
    output logic                    busy,
    output logic                    done
);

    state_t                  r_state;
    logic [CH_NUM*WIDTH-1:0] r_snap;
    logic [WIDTH-1:0]        r_out;
    logic [SEL_W-1:0]        r_sel;
    logic                    r_valid;
    logic                    r_sof;
    logic                    r_busy;
    logic                    r_done;

    logic [SEL_W-1:0]        w_next_sel;
    logic [WIDTH-1:0]        w_next_out;
    logic                    w_accept;
    logic                    w_last;

    assign w_next_sel = r_sel + SEL_W'(1);
    assign w_accept   = r_valid && ready;
    assign w_last     = (r_sel == LAST_SEL);

    // Data for the beat after the current one is looked up ahead of time so
    // that out can stay a register and still change on the accepting edge.
    mux8_slice #(.WIDTH(WIDTH)) u_next_mux (
        .i_data (r_snap),
        .i_sel  (w_next_sel),
        .o_data (w_next_out)
    );

    // Frame FSM: capture, per-beat advance with backpressure, back-to-back restart.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_snap  <= '0;
            r_out   <= '0;
            r_sel   <= '0;
            r_valid <= 1'b0;
            r_sof   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= SEND;
                        r_snap  <= din;
                        r_out   <= din[WIDTH-1:0];
                        r_sel   <= FIRST_SEL;
                        r_valid <= 1'b1;
                        r_sof   <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                SEND: begin
                    if (w_accept) begin
                        if (w_last) begin
                            r_done <= 1'b1;
                            if (start) begin
                                // Restart in place: no idle gap between frames.
                                r_snap <= din;
                                r_out  <= din[WIDTH-1:0];
                                r_sel  <= FIRST_SEL;
                                r_sof  <= 1'b1;
                            end else begin
                                r_state <= IDLE;
                                r_out   <= '0;
                                r_sel   <= FIRST_SEL;
                                r_valid <= 1'b0;
                                r_sof   <= 1'b0;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_sel <= w_next_sel;
                            r_out <= w_next_out;
                            r_sof <= 1'b0;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out   = r_out;
    assign sel   = r_sel;
    assign valid = r_valid;
    assign sof   = r_sof;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: tb/tb_tdm_mux8_tx.sv
// Scoreboard bench for tdm_mux8_tx (WIDTH=1): a frame-level model queues the
// eight expected beats at each capture; a negedge monitor checks every beat.
module tb_tdm_mux8_tx;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] din;
    logic       ready;
    logic [0:0] out;
    logic [2:0] sel;
    logic       valid;
    logic       sof;
    logic       busy;
    logic       done;

    typedef struct {
        int sel;
        int data;
        int sof;
    } beat_t;

    beat_t sb[$];
    int    m_left;
    int    exp_done;
    int    checks;
    int    errors;

    tdm_mux8_tx #(.WIDTH(1)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .din   (din),
        .ready (ready),
        .out   (out),
        .sel   (sel),
        .valid (valid),
        .sof   (sof),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: a frame is eight beats; a new frame may be captured
    // when nothing is in flight or on the edge that accepts the final beat.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sb.delete();
            m_left   = 0;
            exp_done = 0;
        end else begin
            exp_done = (m_left == 1 && ready) ? 1 : 0;
            if (m_left > 0 && ready) m_left--;
            if (start && m_left == 0) begin
                for (int k = 0; k < 8; k++) begin
                    beat_t b;
                    b.sel  = k;
                    b.data = int'(din[k]);
                    b.sof  = (k == 0) ? 1 : 0;
                    sb.push_back(b);
                end
                m_left = 8;
            end
        end
    end

    // Monitor: compare presented beat with queue head; pop when accepted.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_valid", int'(valid), 0);
            chk("rst_busy",  int'(busy),  0);
            chk("rst_done",  int'(done),  0);
            chk("rst_sel",   int'(sel),   0);
            chk("rst_out",   int'(out),   0);
            chk("rst_sof",   int'(sof),   0);
        end else begin
            chk("done",  int'(done),  exp_done);
            chk("valid", int'(valid), (m_left > 0) ? 1 : 0);
            chk("busy",  int'(busy),  (m_left > 0) ? 1 : 0);
            if (valid) begin
                if (sb.size() == 0) begin
                    chk("sb_nonempty", 0, 1);
                end else begin
                    chk("beat_sel", int'(sel), sb[0].sel);
                    chk("beat_out", int'(out), sb[0].data);
                    chk("beat_sof", int'(sof), sb[0].sof);
                    if (ready) void'(sb.pop_front());
                end
            end else begin
                chk("idle_sel", int'(sel), 0);
                chk("idle_sof", int'(sof), 0);
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_left = 0;
        exp_done = 0;
        rst = 1'b1; start = 1'b1; din = 8'hA5; ready = 1'b0;
        step(3);
        rst = 1'b0; start = 1'b0;
        step(3);

        // Single frame, free-running ready.
        din = 8'b1010_0101; ready = 1'b1; start = 1'b1;
        step(1);
        start = 1'b0;
        step(10);

        // Backpressure at sel=3 for three cycles.
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(3);
        ready = 1'b0;
        step(3);
        ready = 1'b1;
        step(8);

        // Back-to-back frame with new data at the last beat.
        din = 8'h5A; start = 1'b1;
        step(1);
        start = 1'b0;
        step(7);
        din = 8'hFF; start = 1'b1;
        step(1);
        start = 1'b0; din = 8'h3C;
        step(10);

        // Ignored start and din change mid-frame.
        din = 8'hA5; start = 1'b1;
        step(1);
        start = 1'b0;
        step(2);
        din = 8'h00; start = 1'b1;
        step(1);
        start = 1'b0;
        step(10);

        // Reset mid-frame at sel=4, then a clean frame.
        din = 8'hC3; start = 1'b1;
        step(1);
        start = 1'b0;
        step(4);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(1);
        din = 8'h96; start = 1'b1;
        step(1);
        start = 1'b0;
        step(10);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            start = ($urandom_range(3) == 0);
            din   = 8'($urandom);
            ready = ($urandom_range(3) != 0);
            rst   = ($urandom_range(99) == 0);
            step(1);
        end
        rst = 1'b0; start = 1'b0; ready = 1'b1;

        // Drain with a bounded wait.
        for (int i = 0; i < 30 && valid; i++) step(1);
        chk("drain_valid", int'(valid), 0);
        chk("drain_sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
